bitmap_anim_sprite: RTL and testbench
=====================================

// Module: bitmap_anim_sprite
// PURPOSE
// - Downstream consumer of the per-object offset stage. Takes the (possibly flipped)
//   sprite-local offsetX/offsetY plus InsideRectangle and returns the sprite pixel
//   colour and a drawing request to the frame mux.
// - Holds NUM_FRAMES animation frames in ROM. Steps through them on startOfFrame
//   ticks under a small play/loop/one-shot FSM.
// - Frame index changes only on startOfFrame, so no frame tears mid-screen.
// PARAMETERS
// - OBJECT_WIDTH_X   11     sprite width in pixels (offsetX range 0..W-1)
// - OBJECT_HEIGHT_Y  48     sprite height in pixels (offsetY range 0..H-1)
// - NUM_FRAMES       4      animation frames in ROM (>=1)
// - FRAME_HOLD       5      startOfFrame ticks each frame is shown (>=1)
// - TRANSPARENT      8'hFF  RGB value treated as "no draw"
// PORTS
// - clk             in   1   system clock
// - resetN          in   1   asynchronous reset, active low
// - offsetX         in   11  sprite-local X from offset stage
// - offsetY         in   11  sprite-local Y from offset stage
// - InsideRectangle in   1   pixel lies within the object's rectangle
// - startOfFrame    in   1   1-cycle pulse per video frame
// - play            in   1   pulse: start looping animation
// - oneShot         in   1   pulse: play frames once, then stop on the last frame
// - stop            in   1   pulse: halt and return to frame 0
// - RGBout          out  8   pixel colour, registered
// - drawingRequest  out  1   pixel is inside the sprite and opaque, registered
// - frameIdx        out  $clog2(NUM_FRAMES) (min 1)  current animation frame
// - animDone        out  1   1-cycle pulse when one-shot reaches its last frame
// BEHAVIOUR
// - Reset (resetN=0, async): state=IDLE, frameIdx=0, holdCnt=0,
//   RGBout=TRANSPARENT, drawingRequest=0, animDone=0. Reset mid-animation aborts it.
// - Pixel path, latency 1 clk:
//   - inRange = InsideRectangle && offsetX<OBJECT_WIDTH_X && offsetY<OBJECT_HEIGHT_Y
//     (unsigned 11-bit compare).
//   - pix = ROM[frameIdx][offsetY][offsetX].
//   - Next clk: RGBout <= inRange ? pix : TRANSPARENT.
//   - Next clk: drawingRequest <= inRange && (pix != TRANSPARENT).
// - FSM states: IDLE, LOOP, ONCE, DONE. Command priority: stop > oneShot > play.
//   - IDLE: frameIdx held at 0. play->LOOP, oneShot->ONCE; holdCnt cleared on entry.
//   - LOOP: on sof, if holdCnt==FRAME_HOLD-1 then holdCnt<=0 and
//     frameIdx <= (frameIdx==NUM_FRAMES-1) ? 0 : frameIdx+1; else holdCnt++.
//     oneShot->ONCE, keeping frameIdx and holdCnt. play is ignored.
//   - ONCE: advance as in LOOP. When the advance would leave NUM_FRAMES-1,
//     stay on NUM_FRAMES-1, go to DONE, and pulse animDone for 1 clk.
//     play->LOOP, keeping position.
//   - DONE: frameIdx held at NUM_FRAMES-1. play->LOOP from frame 0.
//     oneShot->ONCE from frame 0.
//   - stop in any state: IDLE, frameIdx<=0, holdCnt<=0 on the next clk.
// - Commands and sof are sampled on the same edge. A command arriving with sof takes
//   effect first; that sof does not advance the frame.
// - NUM_FRAMES==1: LOOP holds frame 0. ONCE goes to DONE after FRAME_HOLD sofs.
// - frameIdx updates only on the sof edge or on a command. All pixels of one video
//   frame read the same frameIdx.
// TESTING
// - Reset release, InsideRectangle=1, offset (0,0), frame-0 pixel=8'h1C
//   -> 1 clk later RGBout=8'h1C, drawingRequest=1.
// - offsetX=11 (out of range), InsideRectangle=1 -> RGBout=8'hFF, drawingRequest=0.
//   Repeat with an opaque pixel but InsideRectangle=0 -> same response.
// - play, then 20 sofs (FRAME_HOLD=5, NUM_FRAMES=4) -> frameIdx 0,1,2,3 every 5 sofs,
//   then wraps to 0 on the 20th sof.
// - oneShot, then 25 sofs -> frameIdx stops at 3 after the 15th sof. animDone pulses
//   exactly once. State DONE holds frame 3.
// - stop and play asserted together on a sof cycle in LOOP at frame 2
//   -> IDLE, frameIdx=0, no advance.
// - resetN dropped mid-ONCE at frame 2, asynchronously between clk edges
//   -> outputs go to reset values immediately. After release, stays in IDLE despite sofs.

Source files
------------

// File: rtl/bitmap_anim_sprite.sv
`default_nettype none
// ============================================================================
//  Module   : bitmap_anim_sprite
//  Purpose  : Animated bitmap sprite. It turns sprite-local offsets into a
//             registered pixel colour and a drawing request. It steps through
//             NUM_FRAMES ROM frames on startOfFrame ticks. The stepping is
//             driven by an idle/loop/one-shot/done controller.
//  Revision : 1.0 - initial release
// ============================================================================
module bitmap_anim_sprite #(
   parameter int         OBJECT_WIDTH_X  = 11,
   parameter int         OBJECT_HEIGHT_Y = 48,
   parameter int         NUM_FRAMES      = 4,
   parameter int         FRAME_HOLD      = 5,
   parameter logic [7:0] TRANSPARENT     = 8'hFF,
   localparam int        FRAME_W         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [10:0]        offsetX,
   input  logic [10:0]        offsetY,
   input  logic               InsideRectangle,
   input  logic               startOfFrame,
   input  logic               play,
   input  logic               oneShot,
   input  logic               stop,
   output logic [7:0]         RGBout,
   output logic               drawingRequest,
   output logic [FRAME_W-1:0] frameIdx,
   output logic               animDone
);

   localparam int                 c_HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam logic [c_HOLD_W-1:0] c_LAST_HOLD  = c_HOLD_W'(FRAME_HOLD - 1);
   localparam logic [FRAME_W-1:0]  c_LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_LOOP = 2'd1;
   localparam logic [1:0] c_ONCE = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]          r_state, w_state_nxt;
   logic [FRAME_W-1:0]  r_frame, w_frame_nxt;
   logic [c_HOLD_W-1:0] r_hold,  w_hold_nxt;
   logic                r_done,  w_done_nxt;
   logic [7:0]          r_rgb;
   logic                r_draw;
   logic                w_hold_end;
   logic                w_in_range;
   logic [7:0]          w_pix;

   // Frame bitmap ROM. The image is a generated colour ramp per frame with a
   // diagonal lattice of transparent pixels. Pixel (0,0) of frame 0 is 8'h1C.
   function automatic logic [7:0] rom_pix(input logic [FRAME_W-1:0] f,
                                          input logic [10:0]        y,
                                          input logic [10:0]        x);
      logic [10:0] w_sel;
      logic [10:0] w_sum;
      w_sel = x ^ y ^ 11'(f);
      w_sum = 11'd28 + (11'(f) << 5) + (y * 11'd3) + x;
      return (w_sel[1:0] == 2'b11) ? TRANSPARENT : w_sum[7:0];
   endfunction

   assign w_hold_end = (r_hold == c_LAST_HOLD);
   assign w_in_range = InsideRectangle
                    && (offsetX < 11'(OBJECT_WIDTH_X))
                    && (offsetY < 11'(OBJECT_HEIGHT_Y));
   assign w_pix      = rom_pix(r_frame, offsetY, offsetX);

   // Animation controller: commands take precedence over the frame tick
   always_comb begin
      w_state_nxt = r_state;
      w_frame_nxt = r_frame;
      w_hold_nxt  = r_hold;
      w_done_nxt  = 1'b0;
      if (stop) begin
         w_state_nxt = c_IDLE;
         w_frame_nxt = '0;
         w_hold_nxt  = '0;
      end else begin
         case (r_state)
            c_IDLE, c_DONE: begin
               if (oneShot) begin
                  w_state_nxt = c_ONCE;
                  w_frame_nxt = '0;
                  w_hold_nxt  = '0;
               end else if (play) begin
                  w_state_nxt = c_LOOP;
                  w_frame_nxt = '0;
                  w_hold_nxt  = '0;
               end
            end
            c_LOOP: begin
               if (oneShot) begin
                  w_state_nxt = c_ONCE;
               end else if (startOfFrame) begin
                  if (w_hold_end) begin
                     w_hold_nxt  = '0;
                     w_frame_nxt = (r_frame == c_LAST_FRAME) ? '0
                                                             : r_frame + FRAME_W'(1);
                  end else begin
                     w_hold_nxt  = r_hold + c_HOLD_W'(1);
                  end
               end
            end
            c_ONCE: begin
               if (play && !oneShot) begin
                  w_state_nxt = c_LOOP;
               end else if (startOfFrame) begin
                  if (w_hold_end) begin
                     w_hold_nxt = '0;
                     if (r_frame == c_LAST_FRAME) begin
                        w_state_nxt = c_DONE;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_frame_nxt = r_frame + FRAME_W'(1);
                     end
                  end else begin
                     w_hold_nxt = r_hold + c_HOLD_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = c_IDLE;
               w_frame_nxt = '0;
               w_hold_nxt  = '0;
            end
         endcase
      end
   end

   // Controller state register; an async reset aborts any animation
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= c_IDLE;
         r_frame <= '0;
         r_hold  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_frame <= w_frame_nxt;
         r_hold  <= w_hold_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Pixel output register: one-clock latency from offsets to colour and request
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_rgb  <= TRANSPARENT;
         r_draw <= 1'b0;
      end else begin
         r_rgb  <= w_in_range ? w_pix : TRANSPARENT;
         r_draw <= w_in_range && (w_pix != TRANSPARENT);
      end
   end

   assign RGBout         = r_rgb;
   assign drawingRequest = r_draw;
   assign frameIdx       = r_frame;
   assign animDone       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bitmap_anim_sprite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitmap_anim_sprite
//  Purpose  : Scoreboard bench for bitmap_anim_sprite. A reference model
//             computes the expected outputs. The model tracks the animation
//             as a play position counted in frame ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitmap_anim_sprite;

   localparam int c_W    = 11;
   localparam int c_H    = 48;
   localparam int c_N    = 4;
   localparam int c_HOLD = 5;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [10:0] offsetX = '0;
   logic [10:0] offsetY = '0;
   logic        InsideRectangle = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        play = 1'b0;
   logic        oneShot = 1'b0;
   logic        stop = 1'b0;
   logic [7:0]  RGBout;
   logic        drawingRequest;
   logic [1:0]  frameIdx;
   logic        animDone;

   bitmap_anim_sprite #(
      .OBJECT_WIDTH_X (c_W),
      .OBJECT_HEIGHT_Y(c_H),
      .NUM_FRAMES     (c_N),
      .FRAME_HOLD     (c_HOLD),
      .TRANSPARENT    (8'hFF)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .InsideRectangle(InsideRectangle),
      .startOfFrame   (startOfFrame),
      .play           (play),
      .oneShot        (oneShot),
      .stop           (stop),
      .RGBout         (RGBout),
      .drawingRequest (drawingRequest),
      .frameIdx       (frameIdx),
      .animDone       (animDone)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rgb;
      logic       dr;
      int         frame;
      logic       done;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   done_pulses = 0;

   // Model: mode 0 idle, 1 loop, 2 once, 3 done. pos = frame ticks into the sequence.
   int m_mode = 0;
   int m_pos  = 0;

   function automatic logic [7:0] ref_pix(input int f, input int y, input int x);
      if ((((x ^ y ^ f) & 3)) == 3) return 8'hFF;
      return 8'((28 + 32 * f + 3 * y + x) & 255);
   endfunction

   function automatic int model_frame();
      return (m_mode == 0) ? 0 : (m_pos / c_HOLD);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int x, input int y, input logic ins, input logic s,
                       input logic p, input logic o, input logic st);
      exp_t e;
      logic inr;
      logic [7:0] pix;
      @(negedge clk);
      offsetX = 11'(x); offsetY = 11'(y); InsideRectangle = ins;
      startOfFrame = s; play = p; oneShot = o; stop = st;
      inr  = ins && (x < c_W) && (y < c_H);
      pix  = ref_pix(model_frame(), y, x);
      e.rgb = inr ? pix : 8'hFF;
      e.dr  = inr && (pix != 8'hFF);
      e.done = 1'b0;
      if (st) begin
         m_mode = 0; m_pos = 0;
      end else if (m_mode == 0 || m_mode == 3) begin
         if (o)      begin m_mode = 2; m_pos = 0; end
         else if (p) begin m_mode = 1; m_pos = 0; end
      end else if (m_mode == 1 && o) begin
         m_mode = 2;
      end else if (m_mode == 2 && p && !o) begin
         m_mode = 1;
      end else if (s) begin
         if (m_mode == 1) m_pos = (m_pos + 1) % (c_N * c_HOLD);
         else if (m_pos + 1 == c_N * c_HOLD) begin m_mode = 3; e.done = 1'b1; end
         else m_pos++;
      end
      e.frame = model_frame();
      q.push_back(e);
   endtask

   task automatic sofs(input int n);
      for (int i = 0; i < n; i++)
         step($urandom_range(0, 10), $urandom_range(0, 47), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: the DUT presents a pixel every clock; compare against the queue
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (animDone === 1'b1) done_pulses++;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("rgb",   32'(RGBout),         32'(e.rgb));
         chk("draw",  32'(drawingRequest), 32'(e.dr));
         chk("frame", 32'(frameIdx),       32'(e.frame));
         chk("done",  32'(animDone),       32'(e.done));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cmd;
      logic s;
      // reset values while held in reset
      repeat (2) @(negedge clk);
      chk("reset_rgb",   32'(RGBout), 32'hFF);
      chk("reset_draw",  32'(drawingRequest), 32'h0);
      chk("reset_frame", 32'(frameIdx), 32'h0);
      chk("reset_done",  32'(animDone), 32'h0);
      resetN = 1'b1;

      // pixel path boundaries
      step(0, 0, 1, 0, 0, 0, 0);
      step(11, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(10, 47, 1, 0, 0, 0, 0);
      step(10, 48, 1, 0, 0, 0, 0);
      step(3, 0, 1, 0, 0, 0, 0);

      // looping play over 20 ticks
      step(0, 0, 1, 0, 1, 0, 0);
      sofs(20);

      // one-shot over 25 ticks; exactly one done pulse
      step(0, 0, 1, 0, 0, 0, 1);
      done_pulses = 0;
      step(0, 0, 1, 0, 0, 1, 0);
      sofs(25);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("done_pulse_count", 32'(done_pulses), 32'd1);

      // stop + play on a tick while looping at frame 2
      step(0, 0, 1, 0, 1, 0, 0);
      sofs(10);
      step(0, 0, 1, 1, 1, 0, 1);
      sofs(6);

      // randomized phase
      for (int i = 0; i < 500; i++) begin
         s   = ($urandom_range(0, 3) == 0);
         cmd = s ? 0 : int'($urandom_range(0, 40));
         step($urandom_range(0, 13), $urandom_range(0, 50), 1'($urandom_range(0, 4) != 0),
              s, cmd == 1, cmd == 2, cmd == 3);
      end

      // async reset mid one-shot at frame 2
      step(0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1, 0);
      sofs(10);
      step(0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      startOfFrame = 1'b0; play = 1'b0; oneShot = 1'b0; stop = 1'b0;
      #2 resetN = 1'b0;
      #1;
      chk("async_rgb",   32'(RGBout), 32'hFF);
      chk("async_draw",  32'(drawingRequest), 32'h0);
      chk("async_frame", 32'(frameIdx), 32'h0);
      chk("async_done",  32'(animDone), 32'h0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      m_mode = 0; m_pos = 0;
      sofs(8);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
